// File: rtl/tts_entity_pkg.sv
// Shared entity-table definitions for the scheduler and the DCU.
// Entity word layout: {ID[13:10], orientation[9:8], tile[7:0]}.
package tts_entity_pkg;

  localparam int ENTITY_W         = 14;
  localparam int NUM_SLOTS        = 9;
  localparam int SLOT_W           = 4;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam int ENT_ID_MSB   = 13;
  localparam int ENT_ID_LSB   = 10;
  localparam int ENT_ORI_MSB  = 9;
  localparam int ENT_ORI_LSB  = 8;
  localparam int ENT_TILE_MSB = 7;
  localparam int ENT_TILE_LSB = 0;

  typedef logic [ENTITY_W-1:0] entity_t;

  localparam entity_t ENTITY_BLANK = 14'h3C00;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_CLEAR  = 1'b1
  } sched_state_e;

  function automatic logic slot_in_range(input logic [SLOT_W-1:0] slot);
    return slot < SLOT_W'(NUM_SLOTS);
  endfunction

endpackage

// File: rtl/entity_table_scheduler_rr_arbiter.sv
// Round-robin arbiter, one-hot grant, combinational from req/enable/pointer.
// Pointer moves to the requester after the winner on every grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    // Walk candidates in priority order starting at the pointer.
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (enable && !found && req[j] && (j == ((int'(ptr_q) + k) % N))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
          ptr_d    = (j == N - 1) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/entity_table_scheduler.sv
// Shadow/live 9-slot entity table with round-robin write arbitration,
// a 9-cycle clear sweep and a single-cycle frame commit at vertical blanking.
module entity_table_scheduler
  import tts_entity_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   counter_H,
  input  logic [9:0]                   counter_V,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [SLOT_W*NUM_REQ-1:0]    req_slot,
  input  logic [ENTITY_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         clear_all,
  output logic [ENTITY_W-1:0]          entity_1,
  output logic [ENTITY_W-1:0]          entity_2,
  output logic [ENTITY_W-1:0]          entity_3,
  output logic [ENTITY_W-1:0]          entity_4,
  output logic [ENTITY_W-1:0]          entity_5,
  output logic [ENTITY_W-1:0]          entity_6,
  output logic [ENTITY_W-1:0]          entity_7,
  output logic [ENTITY_W-1:0]          entity_8_Flip,
  output logic [ENTITY_W-1:0]          entity_9_Flip,
  output logic                         frame_commit,
  output logic                         bad_slot
);

  entity_t      shadow_q [NUM_SLOTS];
  entity_t      shadow_d [NUM_SLOTS];
  entity_t      live_q   [NUM_SLOTS];
  entity_t      live_d   [NUM_SLOTS];
  sched_state_e state_q, state_d;
  logic [SLOT_W-1:0] clr_idx_q, clr_idx_d;
  logic         pending_q, pending_d;
  logic         frame_commit_q, frame_commit_d;
  logic         bad_slot_q, bad_slot_d;

  logic               commit_point;
  logic               commit_now;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               wr_en;
  logic [SLOT_W-1:0]  sel_slot;
  entity_t            sel_data;

  assign commit_point = (counter_V == 10'(V_ACTIVE)) && (counter_H == 10'd0);
  // A deferred commit fires on the first ACCEPT cycle after a sweep.
  assign commit_now   = (state_q == ST_ACCEPT) && (commit_point || pending_q);
  assign arb_en       = reset && (state_q == ST_ACCEPT) && !commit_now;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (reset),
    .req    (req_valid),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  always_comb begin
    sel_slot = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_slot = req_slot[SLOT_W*i +: SLOT_W];
        sel_data = req_data[ENTITY_W*i +: ENTITY_W];
      end
    end
  end

  assign wr_en = grant_any && slot_in_range(sel_slot);

  always_comb begin
    state_d        = state_q;
    clr_idx_d      = clr_idx_q;
    pending_d      = pending_q;
    shadow_d       = shadow_q;
    live_d         = live_q;
    frame_commit_d = commit_now;
    bad_slot_d     = grant_any && !slot_in_range(sel_slot);

    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wr_en && (sel_slot == SLOT_W'(s))) begin
        shadow_d[s] = sel_data;
      end
    end

    if (commit_now) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end

    case (state_q)
      ST_ACCEPT: begin
        if (clear_all) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (clr_idx_q == SLOT_W'(s)) begin
            shadow_d[s] = ENTITY_BLANK;
          end
        end
        if (clr_idx_q == SLOT_W'(NUM_SLOTS - 1)) begin
          state_d   = ST_ACCEPT;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
        if (commit_point) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_ACCEPT;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_ACCEPT;
      clr_idx_q      <= '0;
      pending_q      <= 1'b0;
      frame_commit_q <= 1'b0;
      bad_slot_q     <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        shadow_q[s] <= ENTITY_BLANK;
        live_q[s]   <= ENTITY_BLANK;
      end
    end else begin
      state_q        <= state_d;
      clr_idx_q      <= clr_idx_d;
      pending_q      <= pending_d;
      frame_commit_q <= frame_commit_d;
      bad_slot_q     <= bad_slot_d;
      shadow_q       <= shadow_d;
      live_q         <= live_d;
    end
  end

  assign entity_1      = live_q[0];
  assign entity_2      = live_q[1];
  assign entity_3      = live_q[2];
  assign entity_4      = live_q[3];
  assign entity_5      = live_q[4];
  assign entity_6      = live_q[5];
  assign entity_7      = live_q[6];
  assign entity_8_Flip = live_q[7];
  assign entity_9_Flip = live_q[8];
  assign frame_commit  = frame_commit_q;
  assign bad_slot      = bad_slot_q;

endmodule

// File: tb/tb_entity_table_scheduler.sv
// Directed bench for entity_table_scheduler: arbitration table plus
// hand-written commit, clear, deferred-commit and bad-slot sequences.
module tb_entity_table_scheduler;

  localparam logic [13:0] BLANK = 14'h3C00;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter_H, counter_V;
  logic [2:0]  req_valid, req_ready;
  logic [11:0] req_slot;
  logic [41:0] req_data;
  logic        clear_all;
  logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5;
  logic [13:0] entity_6, entity_7, entity_8_Flip, entity_9_Flip;
  logic        frame_commit, bad_slot;

  logic [13:0] ent      [9];
  logic [13:0] exp_live [9];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] vld;
    logic [2:0] exp_rdy;
  } rr_vec_t;

  rr_vec_t rr_tab [10];

  entity_table_scheduler #(.NUM_REQ(3), .V_ACTIVE(480)) dut (
    .clk           (clk),
    .reset         (reset),
    .counter_H     (counter_H),
    .counter_V     (counter_V),
    .req_valid     (req_valid),
    .req_slot      (req_slot),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .clear_all     (clear_all),
    .entity_1      (entity_1),
    .entity_2      (entity_2),
    .entity_3      (entity_3),
    .entity_4      (entity_4),
    .entity_5      (entity_5),
    .entity_6      (entity_6),
    .entity_7      (entity_7),
    .entity_8_Flip (entity_8_Flip),
    .entity_9_Flip (entity_9_Flip),
    .frame_commit  (frame_commit),
    .bad_slot      (bad_slot)
  );

  always #5 clk = ~clk;

  assign ent[0] = entity_1;
  assign ent[1] = entity_2;
  assign ent[2] = entity_3;
  assign ent[3] = entity_4;
  assign ent[4] = entity_5;
  assign ent[5] = entity_6;
  assign ent[6] = entity_7;
  assign ent[7] = entity_8_Flip;
  assign ent[8] = entity_9_Flip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_live(input string name);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s entity%0d", name, i + 1), 32'(ent[i]), 32'(exp_live[i]));
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [3:0] s, input logic [13:0] d);
    req_valid[i]        = v;
    req_slot[4*i +: 4]  = s;
    req_data[14*i +: 14] = d;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic commit_cycle();
    counter_V = 10'd480;
    counter_H = 10'd0;
    adv();
    counter_V = 10'd0;
    counter_H = 10'd100;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rr_tab[0] = '{3'b111, 3'b001};
    rr_tab[1] = '{3'b111, 3'b010};
    rr_tab[2] = '{3'b111, 3'b100};
    rr_tab[3] = '{3'b111, 3'b001};
    rr_tab[4] = '{3'b101, 3'b100};
    rr_tab[5] = '{3'b110, 3'b010};
    rr_tab[6] = '{3'b011, 3'b001};
    rr_tab[7] = '{3'b000, 3'b000};
    rr_tab[8] = '{3'b001, 3'b001};
    rr_tab[9] = '{3'b100, 3'b100};

    reset = 1'b0;
    req_valid = '0; req_slot = '0; req_data = '0;
    clear_all = 1'b0;
    counter_V = 10'd0; counter_H = 10'd100;
    for (int i = 0; i < 9; i++) exp_live[i] = BLANK;
    #12 reset = 1'b1;
    adv();

    // Power-on state
    smp();
    chk_live("por");
    chk("por ready", 32'(req_ready), 32'd0);
    chk("por frame_commit", 32'(frame_commit), 32'd0);
    chk("por bad_slot", 32'(bad_slot), 32'd0);

    // Populate live slot 0 so the mid-run reset has something to wipe
    drive(0, 1'b1, 4'd0, 14'h1111);
    smp();
    chk("pre ready", 32'(req_ready), 32'b001);
    adv();
    req_valid = '0;
    commit_cycle();
    smp();
    exp_live[0] = 14'h1111;
    chk_live("pre commit");

    // Mid-run asynchronous reset with all requesters valid
    drive(0, 1'b1, 4'd0, 14'h0001);
    drive(1, 1'b1, 4'd1, 14'h0002);
    drive(2, 1'b1, 4'd2, 14'h0003);
    reset = 1'b0;
    #2;
    for (int i = 0; i < 9; i++) exp_live[i] = BLANK;
    chk_live("reset");
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset frame_commit", 32'(frame_commit), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    adv();

    // Write slot 2, visible only after the commit edge
    drive(0, 1'b1, 4'd2, 14'h0512);
    smp();
    chk("w2 ready", 32'(req_ready), 32'b001);
    adv();
    req_valid = '0;
    smp();
    chk("w2 early entity3", 32'(entity_3), 32'(BLANK));
    repeat (3) adv();
    counter_V = 10'd480; counter_H = 10'd0;
    smp();
    chk("w2 commit-cycle entity3", 32'(entity_3), 32'(BLANK));
    chk("w2 commit-cycle frame_commit", 32'(frame_commit), 32'd0);
    adv();
    counter_V = 10'd0; counter_H = 10'd100;
    smp();
    exp_live[2] = 14'h0512;
    chk_live("w2 committed");
    chk("w2 frame_commit pulse", 32'(frame_commit), 32'd1);
    adv();
    smp();
    chk("w2 frame_commit end", 32'(frame_commit), 32'd0);

    // Round-robin table from a fresh pointer
    pulse_reset();
    for (int i = 0; i < 9; i++) exp_live[i] = BLANK;
    drive(0, 1'b0, 4'd0, 14'h0101);
    drive(1, 1'b0, 4'd1, 14'h0202);
    drive(2, 1'b0, 4'd2, 14'h0303);
    for (int v = 0; v < 10; v++) begin
      req_valid = rr_tab[v].vld;
      smp();
      chk($sformatf("rr vec%0d ready", v), 32'(req_ready), 32'(rr_tab[v].exp_rdy));
      adv();
    end
    req_valid = '0;
    commit_cycle();
    smp();
    exp_live[0] = 14'h0101; exp_live[1] = 14'h0202; exp_live[2] = 14'h0303;
    chk_live("rr commit");
    chk("rr frame_commit", 32'(frame_commit), 32'd1);

    // Request held across the commit point
    drive(1, 1'b1, 4'd4, 14'h1A55);
    counter_V = 10'd480; counter_H = 10'd0;
    smp();
    chk("conflict commit-cycle ready", 32'(req_ready), 32'd0);
    adv();
    counter_V = 10'd0; counter_H = 10'd100;
    smp();
    chk("conflict next ready", 32'(req_ready), 32'b010);
    adv();
    req_valid = '0;
    smp();
    chk_live("conflict same frame");
    commit_cycle();
    smp();
    exp_live[4] = 14'h1A55;
    chk_live("conflict next frame");

    // Out-of-range slot
    drive(2, 1'b1, 4'd12, 14'h2BAD);
    smp();
    chk("bad ready", 32'(req_ready), 32'b100);
    adv();
    drive(0, 1'b1, 4'd0, 14'h0101);
    drive(1, 1'b1, 4'd1, 14'h0202);
    drive(2, 1'b1, 4'd2, 14'h0303);
    smp();
    chk("bad pulse", 32'(bad_slot), 32'd1);
    chk("bad ptr advanced", 32'(req_ready), 32'b001);
    adv();
    req_valid = '0;
    smp();
    chk("bad pulse end", 32'(bad_slot), 32'd0);
    commit_cycle();
    smp();
    chk_live("bad no change");

    // Fill all nine slots, then clear
    for (int s = 0; s < 9; s++) begin
      drive(0, 1'b1, 4'(s), 14'h2000 | 14'(s));
      smp();
      chk($sformatf("fill%0d ready", s), 32'(req_ready), 32'b001);
      adv();
      exp_live[s] = 14'h2000 | 14'(s);
    end
    req_valid = '0;
    commit_cycle();
    smp();
    chk_live("filled");

    clear_all = 1'b1;
    adv();
    clear_all = 1'b0;
    drive(1, 1'b1, 4'd3, 14'h0777);
    for (int c = 0; c < 9; c++) begin
      clear_all = (c == 3);
      smp();
      chk($sformatf("clear busy%0d ready", c), 32'(req_ready), 32'd0);
      adv();
    end
    clear_all = 1'b0;
    smp();
    chk("clear done ready", 32'(req_ready), 32'b010);
    adv();
    req_valid = '0;
    commit_cycle();
    smp();
    for (int i = 0; i < 9; i++) exp_live[i] = BLANK;
    exp_live[3] = 14'h0777;
    chk_live("cleared");

    // Deferred commit: clear_all three cycles before the commit point
    drive(0, 1'b1, 4'd0, 14'h0C0C);
    smp();
    chk("def pre ready", 32'(req_ready), 32'b001);
    adv();
    req_valid = '0;
    commit_cycle();
    smp();
    exp_live[0] = 14'h0C0C;
    chk_live("def pre commit");

    clear_all = 1'b1;
    adv();
    clear_all = 1'b0;
    drive(0, 1'b1, 4'd5, 14'h0ABC);
    for (int k = -2; k <= 8; k++) begin
      if (k == 0) begin
        counter_V = 10'd480; counter_H = 10'd0;
      end else begin
        counter_V = 10'd0; counter_H = 10'd100;
      end
      smp();
      chk($sformatf("def k%0d frame_commit", k), 32'(frame_commit), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("def k%0d entity1", k), 32'(entity_1), (k <= 7) ? 32'h0C0C : 32'(BLANK));
      chk($sformatf("def k%0d entity4", k), 32'(entity_4), (k <= 7) ? 32'h0777 : 32'(BLANK));
      chk($sformatf("def k%0d ready", k), 32'(req_ready), (k == 8) ? 32'b001 : 32'd0);
      adv();
    end
    req_valid = '0;
    counter_V = 10'd0; counter_H = 10'd100;
    smp();
    chk("def frame_commit end", 32'(frame_commit), 32'd0);
    commit_cycle();
    smp();
    for (int i = 0; i < 9; i++) exp_live[i] = BLANK;
    exp_live[5] = 14'h0ABC;
    chk_live("def final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
